// File: rtl/ram_loader.sv
// RAM16K front-end: CPU write pass-through in IDLE, or loader-owned constant
// fill / high-byte-first stream load into sequential addresses from 0.
module ram_loader #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16384
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W:0]   word_count,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              abort,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              cpu_load,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_in,
   output logic              ram_load,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_HI, S_RX_LO, S_WRITE, S_FILL, S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     cnt_q;
   logic [ADDR_W:0]     len_q;
   logic [DATA_W-1:0]   word_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;
   logic                byte_ready_q;
   logic [ADDR_W:0]     cnt_d;
   logic                legal;

   assign cnt_d = cnt_q + ONE_C;
   assign legal = (word_count != '0) && (word_count <= DEPTH_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         word_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         byte_ready_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (legal) begin
                     len_q  <= word_count;
                     word_q <= fill_value;
                     addr_q <= '0;
                     cnt_q  <= '0;
                     busy_q <= 1'b1;
                     if (mode) begin
                        state_q <= S_FILL;
                     end else begin
                        state_q      <= S_RX_HI;
                        byte_ready_q <= 1'b1;
                     end
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            S_RX_HI, S_RX_LO: begin
               if (abort) begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  byte_ready_q <= 1'b0;
               end else if (byte_valid) begin
                  if (state_q == S_RX_HI) begin
                     word_q[15:8] <= byte_in;
                     state_q      <= S_RX_LO;
                  end else begin
                     word_q[7:0]  <= byte_in;
                     state_q      <= S_WRITE;
                     byte_ready_q <= 1'b0;
                  end
               end
            end
            S_WRITE, S_FILL: begin
               // The write of this cycle happens regardless of abort; only the successor changes.
               addr_q <= addr_q + 1'b1;
               cnt_q  <= cnt_d;
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_d == len_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (state_q == S_WRITE) begin
                  state_q      <= S_RX_HI;
                  byte_ready_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q      <= S_IDLE;
               busy_q       <= 1'b0;
               byte_ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      ram_load    = 1'b0;
      ram_address = cpu_address;
      ram_in      = cpu_in;
      if (state_q == S_IDLE) begin
         ram_load = cpu_load & reset;
      end else begin
         ram_load    = reset & ((state_q == S_WRITE) || (state_q == S_FILL));
         ram_address = addr_q;
         ram_in      = word_q;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign byte_ready = byte_ready_q;

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream stage for RAM16K: owns its load/address/in inputs.
- Normal operation: passes CPU write requests straight through to the RAM.
- On command, takes the RAM over and does one of two things:
  - fills a contiguous region from address 0 with a constant, or
  - streams bytes from a byte source (e.g. UART receiver), assembles them high-byte-first into 16-bit words and writes them to sequential addresses.
- Used for program/data loading and memory clear after FPGA configuration.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 16, RAM word width; must be 16 (two bytes per word).
- DEPTH, 16384, number of RAM words; maximum legal word_count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle command strobe, sampled only in IDLE.
- mode  in  1  0 = stream load, 1 = constant fill; sampled with start.
- word_count  in  15  number of words to write, legal 1..DEPTH; sampled with start.
- fill_value  in  16  fill constant; sampled with start.
- abort  in  1  terminate the active operation.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte this cycle.
- cpu_load  in  1  CPU write enable.
- cpu_address  in  14  CPU address.
- cpu_in  in  16  CPU write data.
- ram_load  out  1  to RAM16K load.
- ram_address  out  14  to RAM16K address.
- ram_in  out  16  to RAM16K in.
- busy  out  1  loader owns the RAM.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse on illegal start.

Behaviour:
- **States:** IDLE, RX_HI, RX_LO, WRITE, FILL, DONE.
- **Reset (reset=0, any time, asynchronous):**
  - State goes to IDLE; address counter and word counter go to 0.
  - busy=0, done=0, error=0, byte_ready=0.
  - ram_load is forced to 0 while reset is low.
- **IDLE:**
  - ram_load/ram_address/ram_in equal cpu_load/cpu_address/cpu_in combinationally, with no added latency.
  - busy=0, byte_ready=0.
- **Start in IDLE:**
  - Illegal word_count (0 or >DEPTH): error=1 next cycle, state stays IDLE, no RAM write.
  - Legal word_count: latch mode, word_count and fill_value; clear addr to 0; next state is RX_HI (mode 0) or FILL (mode 1); busy=1 from the next cycle.
  - start is ignored outside IDLE.
- **While busy:**
  - CPU inputs are ignored and not queued.
  - ram_address = addr register; ram_in = word register.
  - ram_load=1 only in WRITE or FILL.
- **RX_HI:**
  - byte_ready=1.
  - On byte_valid&&byte_ready: word[15:8] ← byte_in, go to RX_LO.
- **RX_LO:**
  - byte_ready=1.
  - On handshake: word[7:0] ← byte_in, go to WRITE.
- **Stream stalls:** RX_HI and RX_LO wait indefinitely with byte_valid low; no timeout.
- **WRITE:**
  - byte_ready=0; ram_load=1 for exactly one cycle at addr with the assembled word.
  - Then addr+1 and count+1.
  - If count reaches word_count, go to DONE; otherwise go to RX_HI.
  - Minimum 3 cycles per word.
- **FILL:**
  - ram_load=1 every cycle; ram_in=fill_value; addr increments every cycle.
  - After word_count write cycles, go to DONE.
  - Throughput is 1 word per cycle.
- **DONE:**
  - done=1 and busy=1 for one cycle, then IDLE.
  - CPU pass-through resumes the cycle after DONE.
- **Address range:**
  - Last written address is word_count−1.
  - DEPTH words ends at 16383; addr never wraps to 0 within an operation.
  - Counters are 15 bits wide so word_count=16384 compares correctly.
- **Abort (busy, not DONE):**
  - Next state is IDLE with no done pulse and no further ram_load.
  - An abort in the WRITE cycle still completes that cycle's write.
  - A partially assembled word is discarded.
  - Abort in IDLE has no effect.
- **Simultaneous events:**
  - abort has priority over handshakes and completion.
  - reset has priority over everything.
- **Outputs:** done and error are registered and never high together.

Test Plan:
- **Fill:** start, mode=1, word_count=4, fill_value=0xBEEF → ram_load=1 for 4 consecutive cycles at addresses 0,1,2,3 with ram_in=0xBEEF; done pulse the following cycle; RAM readback of 0..3 = 0xBEEF and address 4 unchanged.
- **Stream with backpressure:** start, mode=0, word_count=2; bytes 0x12,0x34,0x56,0x78 with byte_valid idle 0–3 random cycles between bytes → writes 0x1234@0 and 0x5678@1; byte_ready low in each WRITE cycle; one done pulse.
- **Illegal start:** word_count=0, then word_count=16385 → error pulse each time, busy stays 0, no ram_load, CPU pass-through intact.
- **Full fill:** word_count=16384 → exactly 16384 write cycles; final address 16383; no write to address 0 after the first cycle; done pulse after the last write.
- **Abort:** stream load with abort asserted after byte 0x12 of word 2 → no write for word 2, busy=0 next cycle, no done pulse; a CPU write then reaches the RAM unchanged.
- **Reset mid-fill:** reset low during FILL at address 100 → ram_load=0 and busy=0 immediately (asynchronous); after release, state is IDLE and a new start works from address 0.
